// File: rtl/vx_pipeline_perf_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vx_pipeline_perf_unit: event/latency counters with snapshot bank          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module vx_pipeline_perf_unit #(
  parameter int CTR_BITS   = 44,
  parameter int NUM_EVENTS = 8,
  parameter int INC_BITS   = 3,
  parameter int NUM_LAT    = 2,
  parameter int OUT_BITS   = 8,
  parameter int SATURATE   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           clear,
  input  logic                           snapshot,
  input  logic [NUM_EVENTS*INC_BITS-1:0] evt_inc,
  input  logic [NUM_LAT-1:0]             lat_req_fire,
  input  logic [NUM_LAT-1:0]             lat_rsp_fire,
  output logic [NUM_EVENTS*CTR_BITS-1:0] evt_count,
  output logic [NUM_LAT*CTR_BITS-1:0]    lat_total,
  output logic [NUM_LAT*CTR_BITS-1:0]    lat_count,
  output logic [NUM_LAT*OUT_BITS-1:0]    outstanding,
  output logic [NUM_EVENTS*CTR_BITS-1:0] snap_evt_count,
  output logic [NUM_LAT*CTR_BITS-1:0]    snap_lat_total,
  output logic [NUM_LAT*CTR_BITS-1:0]    snap_lat_count,
  output logic                           snap_valid,
  output logic [NUM_EVENTS+2*NUM_LAT-1:0] overflow,
  output logic [NUM_LAT-1:0]             proto_err
);

  localparam int NUM_OVF = NUM_EVENTS + 2*NUM_LAT;
  localparam logic [OUT_BITS-1:0] OUT_MAX = '1;

  logic [NUM_EVENTS-1:0][CTR_BITS-1:0] evt_q, evt_d, snap_evt_q, snap_evt_d;
  logic [NUM_LAT-1:0][CTR_BITS-1:0]    tot_q, tot_d, snap_tot_q, snap_tot_d;
  logic [NUM_LAT-1:0][CTR_BITS-1:0]    cnt_q, cnt_d, snap_cnt_q, snap_cnt_d;
  logic [NUM_LAT-1:0][OUT_BITS-1:0]    out_q, out_d;
  logic [NUM_OVF-1:0]                  ovf_q, ovf_d;
  logic [NUM_LAT-1:0]                  perr_q, perr_d;
  logic                                snap_valid_q, snap_valid_d;

  logic [NUM_EVENTS-1:0][CTR_BITS:0] evt_sum;
  logic [NUM_LAT-1:0][CTR_BITS:0]    tot_sum, cnt_sum;

  // The carry bit of the widened sum drives both the overflow flag and saturation.
  function automatic logic [CTR_BITS-1:0] fold(input logic [CTR_BITS:0] s);
    if ((SATURATE != 0) && s[CTR_BITS]) return '1;
    return s[CTR_BITS-1:0];
  endfunction

  always_comb begin
    evt_d        = evt_q;
    tot_d        = tot_q;
    cnt_d        = cnt_q;
    out_d        = out_q;
    ovf_d        = ovf_q;
    perr_d       = perr_q;
    snap_evt_d   = snap_evt_q;
    snap_tot_d   = snap_tot_q;
    snap_cnt_d   = snap_cnt_q;
    snap_valid_d = snapshot;

    for (int i = 0; i < NUM_EVENTS; i++) begin
      evt_sum[i] = {1'b0, evt_q[i]} + {1'b0, CTR_BITS'(evt_inc[i*INC_BITS +: INC_BITS])};
      if (enable) begin
        evt_d[i] = fold(evt_sum[i]);
        if (evt_sum[i][CTR_BITS]) ovf_d[i] = 1'b1;
      end
    end

    for (int j = 0; j < NUM_LAT; j++) begin
      // Latency accrues on the in-flight count as it stood entering this cycle.
      tot_sum[j] = {1'b0, tot_q[j]} + {1'b0, CTR_BITS'(out_q[j])};
      cnt_sum[j] = {1'b0, cnt_q[j]} + {1'b0, CTR_BITS'(lat_rsp_fire[j])};
      if (enable) begin
        tot_d[j] = fold(tot_sum[j]);
        cnt_d[j] = fold(cnt_sum[j]);
        if (tot_sum[j][CTR_BITS]) ovf_d[NUM_EVENTS + j] = 1'b1;
        if (cnt_sum[j][CTR_BITS]) ovf_d[NUM_EVENTS + NUM_LAT + j] = 1'b1;
      end

      case ({lat_req_fire[j], lat_rsp_fire[j]})
        2'b10: begin
          if (out_q[j] == OUT_MAX) perr_d[j] = 1'b1;
          else                     out_d[j]  = out_q[j] + OUT_BITS'(1);
        end
        2'b01: begin
          if (out_q[j] == '0) perr_d[j] = 1'b1;
          else                out_d[j]  = out_q[j] - OUT_BITS'(1);
        end
        default: ;
      endcase
    end

    // Trackers mirror real in-flight traffic, so clear leaves them alone.
    if (clear) begin
      evt_d  = '0;
      tot_d  = '0;
      cnt_d  = '0;
      ovf_d  = '0;
      perr_d = '0;
    end

    if (snapshot) begin
      snap_evt_d = evt_q;
      snap_tot_d = tot_q;
      snap_cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_q        <= '0;
      tot_q        <= '0;
      cnt_q        <= '0;
      out_q        <= '0;
      ovf_q        <= '0;
      perr_q       <= '0;
      snap_evt_q   <= '0;
      snap_tot_q   <= '0;
      snap_cnt_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      evt_q        <= evt_d;
      tot_q        <= tot_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      ovf_q        <= ovf_d;
      perr_q       <= perr_d;
      snap_evt_q   <= snap_evt_d;
      snap_tot_q   <= snap_tot_d;
      snap_cnt_q   <= snap_cnt_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign evt_count      = evt_q;
  assign lat_total      = tot_q;
  assign lat_count      = cnt_q;
  assign outstanding    = out_q;
  assign snap_evt_count = snap_evt_q;
  assign snap_lat_total = snap_tot_q;
  assign snap_lat_count = snap_cnt_q;
  assign snap_valid     = snap_valid_q;
  assign overflow       = ovf_q;
  assign proto_err      = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_pipeline_perf_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vx_pipeline_perf_unit: wrap and saturate instances against a model     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_vx_pipeline_perf_unit;
  localparam int NE = 8, NL = 2, CB = 8, IB = 3, OB = 8;
  localparam int CMAX = (1 << CB) - 1;
  localparam int OMAX = (1 << OB) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0, clear = 1'b0, snapshot = 1'b0;
  logic [NE*IB-1:0] evt_inc = '0;
  logic [NL-1:0] req = '0, rsp = '0;

  logic [NE*CB-1:0] o_evt [2], o_sevt [2];
  logic [NL*CB-1:0] o_tot [2], o_cnt [2], o_stot [2], o_scnt [2];
  logic [NL*OB-1:0] o_out [2];
  logic             o_sv [2];
  logic [NE+2*NL-1:0] o_ovf [2];
  logic [NL-1:0]    o_perr [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar s = 0; s < 2; s++) begin : g_dut
    vx_pipeline_perf_unit #(
      .CTR_BITS(CB), .NUM_EVENTS(NE), .INC_BITS(IB),
      .NUM_LAT(NL), .OUT_BITS(OB), .SATURATE(s)
    ) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear), .snapshot(snapshot),
      .evt_inc(evt_inc), .lat_req_fire(req), .lat_rsp_fire(rsp),
      .evt_count(o_evt[s]), .lat_total(o_tot[s]), .lat_count(o_cnt[s]),
      .outstanding(o_out[s]), .snap_evt_count(o_sevt[s]), .snap_lat_total(o_stot[s]),
      .snap_lat_count(o_scnt[s]), .snap_valid(o_sv[s]), .overflow(o_ovf[s]),
      .proto_err(o_perr[s])
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer counters, index 0 wraps, index 1 saturates.
  int m_evt [2][NE], m_tot [2][NL], m_cnt [2][NL];
  int s_evt [2][NE], s_tot [2][NL], s_cnt [2][NL];
  int m_out [NL];
  bit m_ovf [2][NE+2*NL];
  bit m_perr [NL];
  bit m_sv;

  function automatic int acc(input int v, input int a, input int sat, output bit c);
    int t;
    t = v + a;
    c = (t > CMAX);
    if (!c) return t;
    return (sat != 0) ? CMAX : t - (CMAX + 1);
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit c;
    if (reset) begin
      m_sv = 1'b0;
      for (int j = 0; j < NL; j++) begin m_out[j] = 0; m_perr[j] = 1'b0; end
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < NE; i++) begin m_evt[s][i] = 0; s_evt[s][i] = 0; end
        for (int j = 0; j < NL; j++) begin
          m_tot[s][j] = 0; m_cnt[s][j] = 0; s_tot[s][j] = 0; s_cnt[s][j] = 0;
        end
        for (int k = 0; k < NE+2*NL; k++) m_ovf[s][k] = 1'b0;
      end
    end else begin
      m_sv = snapshot;
      for (int s = 0; s < 2; s++) begin
        if (snapshot) begin
          s_evt[s] = m_evt[s]; s_tot[s] = m_tot[s]; s_cnt[s] = m_cnt[s];
        end
        if (enable) begin
          for (int i = 0; i < NE; i++) begin
            m_evt[s][i] = acc(m_evt[s][i], int'(evt_inc[i*IB +: IB]), s, c);
            if (c) m_ovf[s][i] = 1'b1;
          end
          for (int j = 0; j < NL; j++) begin
            m_tot[s][j] = acc(m_tot[s][j], m_out[j], s, c);
            if (c) m_ovf[s][NE+j] = 1'b1;
            m_cnt[s][j] = acc(m_cnt[s][j], int'(rsp[j]), s, c);
            if (c) m_ovf[s][NE+NL+j] = 1'b1;
          end
        end
        if (clear) begin
          for (int i = 0; i < NE; i++) m_evt[s][i] = 0;
          for (int j = 0; j < NL; j++) begin m_tot[s][j] = 0; m_cnt[s][j] = 0; end
          for (int k = 0; k < NE+2*NL; k++) m_ovf[s][k] = 1'b0;
        end
      end
      for (int j = 0; j < NL; j++) begin
        if (req[j] && !rsp[j]) begin
          if (m_out[j] == OMAX) m_perr[j] = 1'b1; else m_out[j]++;
        end else if (rsp[j] && !req[j]) begin
          if (m_out[j] == 0) m_perr[j] = 1'b1; else m_out[j]--;
        end
      end
      if (clear) for (int j = 0; j < NL; j++) m_perr[j] = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    logic [63:0] e1, e2, e3, e4, e5, e6, e7, e8;
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        e1 = '0; e2 = '0; e3 = '0; e4 = '0; e5 = '0; e6 = '0; e7 = '0; e8 = '0;
        for (int i = 0; i < NE; i++) begin
          e1[i*CB +: CB] = CB'(m_evt[s][i]);
          e2[i*CB +: CB] = CB'(s_evt[s][i]);
        end
        for (int j = 0; j < NL; j++) begin
          e3[j*CB +: CB] = CB'(m_tot[s][j]);
          e4[j*CB +: CB] = CB'(m_cnt[s][j]);
          e5[j*CB +: CB] = CB'(s_tot[s][j]);
          e6[j*CB +: CB] = CB'(s_cnt[s][j]);
          e7[j*OB +: OB] = OB'(m_out[j]);
          e8[j] = m_perr[j];
        end
        chk($sformatf("evt_count[%0d]", s), o_evt[s], e1);
        chk($sformatf("snap_evt_count[%0d]", s), o_sevt[s], e2);
        chk($sformatf("lat_total[%0d]", s), 64'(o_tot[s]), e3);
        chk($sformatf("lat_count[%0d]", s), 64'(o_cnt[s]), e4);
        chk($sformatf("snap_lat_total[%0d]", s), 64'(o_stot[s]), e5);
        chk($sformatf("snap_lat_count[%0d]", s), 64'(o_scnt[s]), e6);
        chk($sformatf("outstanding[%0d]", s), 64'(o_out[s]), e7);
        chk($sformatf("proto_err[%0d]", s), 64'(o_perr[s]), e8);
        e1 = '0;
        for (int k = 0; k < NE+2*NL; k++) e1[k] = m_ovf[s][k];
        chk($sformatf("overflow[%0d]", s), 64'(o_ovf[s]), e1);
        chk($sformatf("snap_valid[%0d]", s), 64'(o_sv[s]), 64'(m_sv));
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  int exp_out [7] = '{1, 2, 2, 2, 1, 1, 0};
  bit req_seq [7] = '{1, 1, 0, 0, 0, 0, 0};
  bit rsp_seq [7] = '{0, 0, 0, 0, 1, 0, 1};

  initial begin
    step(2);
    chk_en = 1'b1;
    for (int s = 0; s < 2; s++) begin
      chk("reset evt_count", o_evt[s], 64'd0);
      chk("reset snap_valid", 64'(o_sv[s]), 64'd0);
      chk("reset overflow", 64'(o_ovf[s]), 64'd0);
    end
    reset = 1'b0;
    step();

    // Steady increments on two channels.
    enable = 1'b1;
    evt_inc = (NE*IB)'((7 << IB) | 3);
    step(10);
    evt_inc = '0;
    for (int s = 0; s < 2; s++) begin
      chk("ch0 after 10", 64'(o_evt[s][7:0]), 64'd30);
      chk("ch1 after 10", 64'(o_evt[s][15:8]), 64'd70);
      chk("other channels", 64'(o_evt[s][63:16]), 64'd0);
    end
    clear = 1'b1; step(); clear = 1'b0;

    // Drive channel 2 to 254, then over the top.
    evt_inc = (NE*IB)'(7 << (2*IB)); step(36);
    evt_inc = (NE*IB)'(2 << (2*IB)); step();
    chk("ch2 at 254 wrap", 64'(o_evt[0][23:16]), 64'd254);
    chk("ch2 at 254 sat", 64'(o_evt[1][23:16]), 64'd254);
    evt_inc = (NE*IB)'(3 << (2*IB)); step();
    chk("ch2 wrapped", 64'(o_evt[0][23:16]), 64'd1);
    chk("ch2 saturated", 64'(o_evt[1][23:16]), 64'd255);
    chk("ovf2 wrap", 64'(o_ovf[0][2]), 64'd1);
    chk("ovf2 sat", 64'(o_ovf[1][2]), 64'd1);
    evt_inc = (NE*IB)'(1 << (2*IB)); step();
    chk("ch2 wrap +1", 64'(o_evt[0][23:16]), 64'd2);
    chk("ch2 sat hold", 64'(o_evt[1][23:16]), 64'd255);
    chk("ovf2 sticky", 64'(o_ovf[0][2]), 64'd1);
    evt_inc = '0; clear = 1'b1; step(); clear = 1'b0;
    chk("ovf cleared", 64'(o_ovf[0]), 64'd0);

    // Stream 0 latency sequence; total reaches 8 before the last response edge.
    for (int c = 0; c < 7; c++) begin
      req[0] = req_seq[c]; rsp[0] = rsp_seq[c];
      step();
      chk($sformatf("lat seq out c%0d", c), 64'(o_out[0][7:0]), 64'(exp_out[c]));
      if (c == 5) chk("lat_total c5", 64'(o_tot[0][7:0]), 64'd8);
    end
    req = '0; rsp = '0;
    chk("lat_total end", 64'(o_tot[0][7:0]), 64'd9);
    chk("lat_count end", 64'(o_cnt[0][7:0]), 64'd2);

    // Tracker protocol errors at both bounds.
    enable = 1'b0;
    rsp[0] = 1'b1; step(); rsp[0] = 1'b0;
    chk("underflow out", 64'(o_out[0][7:0]), 64'd0);
    chk("underflow perr", 64'(o_perr[0]), 64'd1);
    clear = 1'b1; step(); clear = 1'b0;
    req[0] = 1'b1; step();
    rsp[0] = 1'b1; step(); rsp[0] = 1'b0;
    chk("req+rsp out", 64'(o_out[0][7:0]), 64'd1);
    chk("req+rsp perr", 64'(o_perr[0]), 64'd0);
    step(254);
    chk("tracker at max", 64'(o_out[0][7:0]), 64'd255);
    step();
    chk("tracker held", 64'(o_out[0][7:0]), 64'd255);
    chk("overrun perr", 64'(o_perr[0]), 64'd1);
    req[0] = 1'b0; rsp[0] = 1'b1; step(255); rsp[0] = 1'b0;
    chk("tracker drained", 64'(o_out[0][7:0]), 64'd0);
    clear = 1'b1; step(); clear = 1'b0;

    // Snapshot coincident with clear.
    enable = 1'b1;
    req[0] = 1'b1; step(); req[0] = 1'b0;
    evt_inc = (NE*IB)'(5);
    step(10);
    chk("ch0 at 50", 64'(o_evt[0][7:0]), 64'd50);
    snapshot = 1'b1; clear = 1'b1; step(); snapshot = 1'b0; clear = 1'b0;
    chk("snap ch0", 64'(o_sevt[0][7:0]), 64'd50);
    chk("snap_valid", 64'(o_sv[0]), 64'd1);
    chk("live ch0 cleared", 64'(o_evt[0][7:0]), 64'd0);
    chk("outstanding kept", 64'(o_out[0][7:0]), 64'd1);
    step();
    chk("snap_valid drop", 64'(o_sv[0]), 64'd0);
    chk("snap held", 64'(o_sevt[0][7:0]), 64'd50);
    snapshot = 1'b1; step(2); snapshot = 1'b0;
    chk("snap_valid back-to-back", 64'(o_sv[1]), 64'd1);
    step();

    // Frozen counters while trackers still move.
    clear = 1'b1; step(); clear = 1'b0;
    enable = 1'b0;
    evt_inc = (NE*IB)'(24'h7777);
    req[0] = 1'b1; step(); req[0] = 1'b0;
    step(4);
    chk("frozen evt", o_evt[0], 64'd0);
    chk("frozen lat_total", 64'(o_tot[0]), 64'd0);
    chk("tracker moved", 64'(o_out[0][7:0]), 64'd2);

    // Asynchronous reset mid-cycle.
    @(posedge clk); #2;
    reset = 1'b1; #1;
    for (int s = 0; s < 2; s++) begin
      chk("async reset out", 64'(o_out[s]), 64'd0);
      chk("async reset sevt", o_sevt[s], 64'd0);
      chk("async reset perr", 64'(o_perr[s]), 64'd0);
    end
    step(2);
    evt_inc = '0;
    reset = 1'b0;
    step(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
